// File: rtl/fetch_controller.sv
// Dual-issue instruction fetch: reads aligned word pairs from synchronous IMEM and presents them to decode.
// Define FETCH_PERF_CNT_EN to add the stall_cycles / flush_count performance counters.
module fetch_controller #(
  parameter int IMEM_WORDS = 512
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          branch_taken,
  input  logic [31:0]                   branch_target,
  output logic                          imem_req,
  output logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
  input  logic [31:0]                   imem_rdata0,
  input  logic [31:0]                   imem_rdata1,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   first_inst,
  output logic [31:0]                   second_inst,
  output logic [31:0]                   pc_out,
  output logic                          halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   flush_count
`endif
);

  localparam int AW = $clog2(IMEM_WORDS);
  localparam logic [31:0]   NOP_INST  = 32'h0020_0000;
  localparam logic [31:0]   LNOP_INST = 32'h4020_0000;
  localparam logic [AW-2:0] PAIR_STEP = 1;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, HALT} state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic            last_q;
  logic            imem_req_q;
  logic [AW-1:0]   imem_addr_q;
  logic            out_valid_q;
  logic [31:0]     first_q;
  logic [31:0]     second_q;
  logic [31:0]     pc_out_q;
  logic            halted_q;

  logic [31:0]     tgt_pc_d;
  logic [AW-1:0]   tgt_addr_d;
  logic [AW-2:0]   adv_pair_d;
  logic [31:0]     adv_pc_d;
  logic [AW-1:0]   adv_addr_d;
  logic            stop0;
  logic            stop1;
  logic            odd_slot;
  logic            redirect;

  // pc_q always holds a word-aligned byte address; bit 2 set means the fetch began on an odd word.
  assign tgt_pc_d   = branch_target & ~32'h3;
  assign tgt_addr_d = {tgt_pc_d[AW+1:3], 1'b0};
  assign adv_pair_d = pc_q[AW+1:3] + PAIR_STEP;
  assign adv_pc_d   = {pc_q[31:AW+2], adv_pair_d, 3'b000};
  assign adv_addr_d = {adv_pair_d, 1'b0};

  assign stop0    = (imem_rdata0[31:21] == 11'd0);
  assign stop1    = (imem_rdata1[31:21] == 11'd0);
  assign odd_slot = pc_q[2];
  assign redirect = branch_taken && (state_q inside {FETCH, WAIT, HOLD});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      last_q      <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      out_valid_q <= 1'b0;
      first_q     <= '0;
      second_q    <= '0;
      pc_out_q    <= '0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pc_q        <= '0;
            imem_addr_q <= '0;
            imem_req_q  <= 1'b1;
            state_q     <= FETCH;
          end
        end
        FETCH, WAIT, HOLD: begin
          if (branch_taken) begin
            // Redirect beats a same-cycle handshake: the held pair is dropped unconsumed.
            pc_q        <= tgt_pc_d;
            imem_addr_q <= tgt_addr_d;
            imem_req_q  <= 1'b1;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            state_q     <= FETCH;
          end else if (state_q == FETCH) begin
            imem_req_q <= 1'b0;
            state_q    <= WAIT;
          end else if (state_q == WAIT) begin
            if (odd_slot ? stop1 : stop0) begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end else begin
              first_q     <= odd_slot ? NOP_INST : imem_rdata0;
              second_q    <= (!odd_slot && stop1) ? LNOP_INST : imem_rdata1;
              last_q      <= !odd_slot && stop1;
              pc_out_q    <= pc_q & ~32'h4;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            if (last_q) begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end else begin
              pc_q        <= adv_pc_d;
              imem_addr_q <= adv_addr_d;
              imem_req_q  <= 1'b1;
              state_q     <= FETCH;
            end
          end
        end
        HALT: begin
          out_valid_q <= 1'b0;
          imem_req_q  <= 1'b0;
          halted_q    <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign out_valid   = out_valid_q;
  assign first_inst  = first_q;
  assign second_inst = second_q;
  assign pc_out      = pc_out_q;
  assign halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (state_q == HOLD && !out_ready && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
      if (redirect && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL: parameter IMEM_WORDS, default 512, instruction-memory depth in 32-bit words (power of two).
REQ-002 SHALL: clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL: reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-004 SHALL: start  in  1  one-cycle pulse; begins fetching from byte address 0 when IDLE.
REQ-005 SHALL: branch_taken  in  1  redirect request, sampled each cycle.
REQ-006 SHALL: branch_target  in  32  redirect byte address, bit 0 MSB.
REQ-007 SHALL: imem_req  out  1  read strobe to synchronous instruction memory.
REQ-008 SHALL: imem_addr  out  log2(IMEM_WORDS)  word index of even-slot word; memory returns words addr and addr+1 (mod IMEM_WORDS).
REQ-009 SHALL: imem_rdata0, imem_rdata1  in  32 each  words at addr/addr+1, valid the cycle after imem_req.
REQ-010 SHALL: out_valid  out  1; out_ready  in  1  valid/ready handshake to decode.
REQ-011 SHALL: first_inst, second_inst  out  32 each  even/odd issue-slot instructions.
REQ-012 SHALL: pc_out  out  32  byte address of the pair's even slot.
REQ-013 SHALL: halted  out  1  program end reached.

Function
REQ-014 SHALL: FSM states IDLE, FETCH, WAIT, HOLD, HALT.
REQ-015 SHALL: IDLE->FETCH on start; FETCH drives imem_req=1 for one cycle ->WAIT; WAIT captures rdata into output registers ->HOLD; HOLD with out_valid&&out_ready ->FETCH (next pair).
REQ-016 SHALL: fetch latency start->out_valid exactly 3 cycles; steady-state throughput one pair per 3 cycles with out_ready held 1.
REQ-017 SHALL: out_valid=1 only in HOLD; first_inst/second_inst/pc_out stable while out_valid=1 and out_ready=0.
REQ-018 SHALL: normal advance: pc += 8 bytes; word index wraps modulo IMEM_WORDS.
REQ-019 SHALL: stop word = bits [0:10] all zero.
REQ-020 SHALL: WAIT with rdata0 stop -> no pair issued, ->HALT.
REQ-021 SHALL: WAIT with rdata0 non-stop, rdata1 stop -> issue first=rdata0, second=LNOP (0x40200000), then after handshake ->HALT.
REQ-022 SHALL: HALT holds out_valid=0, halted=1, imem_req=0 until reset; start ignored.
REQ-023 SHALL: branch_taken=1 in FETCH, WAIT or HOLD: discard in-flight read and held pair (out_valid=0 next cycle), pc <= branch_target with bits [30:31] forced 0, ->FETCH; branch_taken has priority over handshake in the same cycle (pair counts as not consumed).
REQ-024 SHALL: redirect target with bit 29=1 (odd word): fetch the enclosing even-aligned pair, present first=NOP (0x00200000), second=word at target, pc_out=target&~4; next pc = target+4.
REQ-025 SHALL: branch_taken ignored in IDLE and HALT.
REQ-026 SHALL: start and branch_taken in the same IDLE cycle: start wins, fetch from 0.

Reset
REQ-027 SHALL: on reset=0: state IDLE, pc=0, out_valid=0, imem_req=0, halted=0, first_inst=0, second_inst=0, pc_out=0, imem_addr=0.
REQ-028 SHALL: reset mid-operation aborts any read/handshake; data returned after reset release from an aborted read is ignored.

Configuration
REQ-029 SHALL: macro FETCH_PERF_CNT_EN defined: add outputs stall_cycles (32, counts HOLD cycles with out_ready=0) and flush_count (32, counts accepted redirects), both reset to 0, saturating at 0xFFFFFFFF; undefined: ports and counters absent, behaviour otherwise identical.

Verification
REQ-030 SHALL: reset release, start, memory words 0..3 = A,B,C,D, out_ready=1 -> pairs (A,B,pc 0) then (C,D,pc 8), first out_valid 3 cycles after start.
REQ-031 SHALL: word 2 = E, word 3 = 0 -> pair (E,0x40200000), then halted=1, out_valid=0 permanently.
REQ-032 SHALL: out_ready=0 for 5 cycles in HOLD -> pair and pc_out unchanged, no imem_req; with FETCH_PERF_CNT_EN stall_cycles=5.
REQ-033 SHALL: branch_taken, target 0x14, during HOLD -> held pair dropped; next pair (0x00200000, word 5), pc_out=0x10; following pc_out=0x18.
REQ-034 SHALL: reset asserted during WAIT -> all outputs zero same cycle, IDLE; second start fetches from address 0.
REQ-035 SHALL: IMEM_WORDS=512, pc at word 510 non-stop -> next imem_addr=0 (wrap).
